// File: rtl/led_pwm_drv.sv
// led_pwm_drv: PWM brightness gate for a bank of LEDs with optional duty fading.
//
// A prescaler produces a tick every PRE_DIV clocks. A PWM_BITS-wide counter
// advances on each tick, and one full wrap of that counter is one PWM period.
// The active duty (cur_duty) only changes at the end of a period, either jumping
// straight to the target duty or stepping one LSB per period toward it.
//
// Ports:
//   i_Sys_clk    - single clock, all logic on rising edge
//   i_Rst        - synchronous active-high reset
//   i_led        - per-LED on/off request from the upstream pattern stage
//   i_brightness - requested target duty
//   i_brt_vld    - single-cycle strobe loading i_brightness as the new target
//   i_fade_en    - 1 = ramp toward target one step per period, 0 = jump
//   o_led        - registered, PWM-gated LED drive
//   o_busy       - registered, high while a fade is in progress
module led_pwm_drv #(
    parameter int LED_NUM  = 8,
    parameter int STS_FREQ = 125_000_000,
    parameter int PWM_FREQ = 1000,
    parameter int PWM_BITS = 8,
    parameter int DEF_BRT  = 2**PWM_BITS - 1
) (
    input  logic                i_Sys_clk,
    input  logic                i_Rst,
    input  logic [LED_NUM-1:0]  i_led,
    input  logic [PWM_BITS-1:0] i_brightness,
    input  logic                i_brt_vld,
    input  logic                i_fade_en,
    output logic [LED_NUM-1:0]  o_led,
    output logic                o_busy
);

    localparam int PRE_RAW = STS_FREQ / (PWM_FREQ * (2**PWM_BITS));
    localparam int PRE_DIV = (PRE_RAW < 1) ? 1 : PRE_RAW;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRE_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_DEF = PWM_BITS'(DEF_BRT);

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] cur_duty;
    logic [PWM_BITS-1:0] tgt_duty;
    state_t              state;
    logic                tick;
    logic                period_end;
    logic                pwm_on;

    assign tick       = (pre_cnt == PRE_LAST);
    assign period_end = tick && (pwm_cnt == DUTY_MAX);

    // Full-scale duty is forced on so the LED never sees a 1-cycle low per period.
    assign pwm_on = (cur_duty == DUTY_MAX) || (pwm_cnt < cur_duty);

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
        end
    end

    // A strobe coinciding with period_end lands here on the same edge the FSM
    // samples the old tgt_duty, so that step still uses the previous target.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            tgt_duty <= DUTY_DEF;
        end else if (i_brt_vld) begin
            tgt_duty <= i_brightness;
        end
    end

    // Steps are gated by a strict compare against the target, so cur_duty can
    // never pass 0 or all-ones and never overshoots. A wrong-direction state
    // (target moved across cur_duty) switches direction without stepping.
    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            state    <= StIdle;
            cur_duty <= DUTY_DEF;
            o_busy   <= 1'b0;
        end else if (period_end) begin
            if (!i_fade_en) begin
                cur_duty <= tgt_duty;
                state    <= StIdle;
                o_busy   <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (cur_duty < tgt_duty) begin
                            state  <= StUp;
                            o_busy <= 1'b1;
                        end else if (cur_duty > tgt_duty) begin
                            state  <= StDown;
                            o_busy <= 1'b1;
                        end else begin
                            o_busy <= 1'b0;
                        end
                    end
                    StUp: begin
                        if (cur_duty < tgt_duty) begin
                            cur_duty <= cur_duty + DUTY_ONE;
                            if (cur_duty + DUTY_ONE == tgt_duty) begin
                                state  <= StIdle;
                                o_busy <= 1'b0;
                            end
                        end else if (cur_duty > tgt_duty) begin
                            state  <= StDown;
                            o_busy <= 1'b1;
                        end else begin
                            state  <= StIdle;
                            o_busy <= 1'b0;
                        end
                    end
                    StDown: begin
                        if (cur_duty > tgt_duty) begin
                            cur_duty <= cur_duty - DUTY_ONE;
                            if (cur_duty - DUTY_ONE == tgt_duty) begin
                                state  <= StIdle;
                                o_busy <= 1'b0;
                            end
                        end else if (cur_duty < tgt_duty) begin
                            state  <= StUp;
                            o_busy <= 1'b1;
                        end else begin
                            state  <= StIdle;
                            o_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= StIdle;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            o_led <= '0;
        end else begin
            o_led <= i_led & {LED_NUM{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pwm_drv.sv
// tb_led_pwm_drv: directed self-checking bench for led_pwm_drv.
// PRE_DIV = 1, so pwm_cnt after n clocks out of reset is n mod 256 and every
// 256-clock window started right after reset release is one PWM period.
module tb_led_pwm_drv;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_led;
    logic [7:0] i_brightness;
    logic       i_brt_vld;
    logic       i_fade_en;
    logic [7:0] o_led;
    logic       o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pwm_drv #(
        .LED_NUM  (8),
        .STS_FREQ (2560),
        .PWM_FREQ (10),
        .PWM_BITS (8)
    ) dut (
        .i_Sys_clk    (clk),
        .i_Rst        (rst),
        .i_led        (i_led),
        .i_brightness (i_brightness),
        .i_brt_vld    (i_brt_vld),
        .i_fade_en    (i_fade_en),
        .o_led        (o_led),
        .o_busy       (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One PWM period: optional strobe before edge strobe_at (1..256), counts
    // cycles with o_led == i_led (high) and cycles neither high nor zero.
    task automatic period(input int strobe_at, input logic [7:0] val,
                          output int hi, output int glitch, output logic busy);
        hi     = 0;
        glitch = 0;
        busy   = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            if (i == strobe_at) begin
                i_brightness = val;
                i_brt_vld    = 1'b1;
            end
            @(posedge clk);
            #1;
            i_brt_vld = 1'b0;
            if (o_led === i_led) hi++;
            else if (o_led !== 8'h00) glitch++;
            if (i == 128) busy = o_busy;
        end
    endtask

    task automatic pchk(input string tag, input int strobe_at, input logic [7:0] val,
                        input int exp_hi, input logic exp_busy);
        int   hi;
        int   glitch;
        logic busy;
        period(strobe_at, val, hi, glitch, busy);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_glitch"}, glitch, 0);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    endtask

    initial begin
        rst          = 1'b1;
        i_led        = 8'hFF;
        i_brightness = 8'h00;
        i_brt_vld    = 1'b0;
        i_fade_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", o_led, 8'h00);
        check("rst_busy", o_busy, 0);
        rst = 1'b0;

        // Default duty all-ones: continuously on, no fade.
        pchk("p0_full", 0, 8'd0, 256, 1'b0);
        pchk("p1_strobe64", 10, 8'd64, 256, 1'b0);
        pchk("p2_d64", 0, 8'd0, 64, 1'b0);
        pchk("p3_d64", 0, 8'd0, 64, 1'b0);

        // Fade 64 -> 68: decide, then one step per period.
        i_fade_en = 1'b1;
        pchk("p4_strobe68", 10, 8'd68, 64, 1'b0);
        pchk("p5_fade", 0, 8'd0, 64, 1'b1);
        pchk("p6_fade", 0, 8'd0, 65, 1'b1);
        pchk("p7_fade", 0, 8'd0, 66, 1'b1);
        pchk("p8_fade", 0, 8'd0, 67, 1'b1);
        pchk("p9_done", 0, 8'd0, 68, 1'b0);

        // Jumps to 0 and to full scale.
        i_fade_en = 1'b0;
        pchk("p10_strobe0", 10, 8'd0, 68, 1'b0);
        pchk("p11_zero", 10, 8'd255, 0, 1'b0);
        pchk("p12_full", 10, 8'd100, 256, 1'b0);
        i_fade_en = 1'b1;
        pchk("p13_strobe200", 10, 8'd200, 100, 1'b0);
        pchk("p14_up", 0, 8'd0, 100, 1'b1);

        // Reset mid-fade.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_led", o_led, 8'h00);
        check("mid_rst_duty", dut.cur_duty, 255);

        // Jump to 50, then fade down toward 20, retargeted to 10 mid-fade.
        i_fade_en = 1'b0;
        pchk("r0_full", 10, 8'd50, 256, 1'b0);
        i_fade_en = 1'b1;
        pchk("r1_d50", 10, 8'd20, 50, 1'b0);
        pchk("r2_down", 0, 8'd0, 50, 1'b1);
        pchk("r3_retarget", 10, 8'd10, 49, 1'b1);
        for (int k = 4; k <= 42; k++) begin
            pchk($sformatf("r%0d_down", k), 0, 8'd0, 52 - k, (k <= 41));
        end

        // Strobe on period_end: step uses old target 12, not new target 5.
        pchk("r43_strobe12", 50, 8'd12, 10, 1'b0);
        pchk("r44_up", 0, 8'd0, 10, 1'b1);
        pchk("r45_pe_strobe", 256, 8'd5, 11, 1'b1);
        pchk("r46_old_tgt", 0, 8'd0, 12, 1'b0);
        pchk("r47_down", 0, 8'd0, 12, 1'b1);
        pchk("r48_down", 0, 8'd0, 11, 1'b1);
        i_fade_en = 1'b0;
        pchk("r49_jump255", 10, 8'd255, 10, 1'b1);

        // i_led changes show after one clock regardless of PWM phase.
        check("full_busy", o_busy, 0);
        i_led = 8'hA5;
        @(posedge clk);
        #1;
        check("led_a5", o_led, 8'hA5);
        i_led = 8'h00;
        @(posedge clk);
        #1;
        check("led_00", o_led, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
